// File: rtl/axis_seq_checker.sv
// axis_seq_checker: AXI-Stream sink that checks an incrementing-count stream.
// Locks onto the first accepted beat, then expects every later beat to be the
// previous beat + 1 (wrapping). Reports mismatch pulses and beat/error stats.
// Optional feature macro: AXIS_SEQ_CHECKER_LFSR_READY_EN -- when defined,
// tready is gated by a 16-bit Galois LFSR for pseudo-random backpressure;
// when undefined, tready simply follows en one cycle later.
`timescale 1ns/1ps
`default_nettype none

module axis_seq_checker #(
  parameter int          BUS_WIDTH      = 1,
  parameter int          ERR_CNT_WIDTH  = 16,
  parameter int          BEAT_CNT_WIDTH = 32,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                      aclk,
  input  logic                      arstn,
  input  logic [8*BUS_WIDTH-1:0]    s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      en,
  input  logic                      clr,
  output logic                      in_sync,
  output logic                      mismatch,
  output logic                      err_sticky,
  output logic [ERR_CNT_WIDTH-1:0]  err_count,
  output logic [BEAT_CNT_WIDTH-1:0] beat_count
);

  localparam int DW = 8 * BUS_WIDTH;

  typedef enum logic {
    SYNC  = 1'b0,
    CHECK = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [DW-1:0]             expected_q, expected_d;
  logic                      tready_q, tready_d;
  logic                      mismatch_q, mismatch_d;
  logic                      err_sticky_q, err_sticky_d;
  logic [ERR_CNT_WIDTH-1:0]  err_count_q, err_count_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_count_q, beat_count_d;
  logic                      rdy_src;
  logic                      accept;

`ifdef AXIS_SEQ_CHECKER_LFSR_READY_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Right-shifting Galois LFSR, x^16+x^14+x^13+x^11+1; free-running every cycle.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // LFSR register; only reset touches it (clr and en leave it running).
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign rdy_src = lfsr_q[0];
`else
  assign rdy_src = 1'b1;
`endif

  assign accept = s_axis_tvalid & tready_q;

  // Next-state: clr wins over everything; en low forces resync but still
  // counts a beat that slipped through on the last ready cycle.
  always_comb begin
    state_d      = state_q;
    expected_d   = expected_q;
    tready_d     = en & rdy_src;
    mismatch_d   = 1'b0;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    beat_count_d = beat_count_q;

    if (clr) begin
      state_d      = SYNC;
      err_sticky_d = 1'b0;
      err_count_d  = '0;
      beat_count_d = '0;
    end else begin
      if (accept) begin
        beat_count_d = beat_count_q + BEAT_CNT_WIDTH'(1);
        if (en) begin
          if (state_q == SYNC) begin
            expected_d = s_axis_tdata + DW'(1);
            state_d    = CHECK;
          end else if (s_axis_tdata == expected_q) begin
            expected_d = expected_q + DW'(1);
          end else begin
            // Resync on the received value so one dropped beat costs one error.
            mismatch_d   = 1'b1;
            err_sticky_d = 1'b1;
            if (!(&err_count_q)) err_count_d = err_count_q + ERR_CNT_WIDTH'(1);
            expected_d   = s_axis_tdata + DW'(1);
          end
        end
      end
      if (!en) state_d = SYNC;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q      <= SYNC;
      expected_q   <= '0;
      tready_q     <= 1'b0;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      expected_q   <= expected_d;
      tready_q     <= tready_d;
      mismatch_q   <= mismatch_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign in_sync       = (state_q == CHECK);
  assign mismatch      = mismatch_q;
  assign err_sticky    = err_sticky_q;
  assign err_count     = err_count_q;
  assign beat_count    = beat_count_q;

endmodule

`default_nettype wire

// File: doc/axis_seq_checker.md
Name: axis_seq_checker

Overview:
- AXI-Stream sink that consumes and checks the incrementing-count streams our stimulus sources push through axis_tiny_fifo and other buffer cores.
- Generates tready backpressure and locks onto the first accepted beat.
- Verifies every later beat equals the previous beat + 1, modulo 2^(8*BUS_WIDTH).
- Exposes beat and error statistics; used at the FIFO master port in benches and as a built-in self-test sink in hardware.

Parameters:
- BUS_WIDTH, 1, tdata width in bytes (tdata = 8*BUS_WIDTH bits).
- ERR_CNT_WIDTH, 16, width of the saturating mismatch counter.
- BEAT_CNT_WIDTH, 32, width of the wrapping accepted-beat counter.
- LFSR_SEED, 16'hACE1, nonzero reset value of the backpressure LFSR (used only with the optional feature).

Ports:
- aclk  in  1  stream clock; all logic is on the rising edge.
- arstn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  8*BUS_WIDTH  stream data.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready (registered).
- en  in  1  checker enable.
- clr  in  1  synchronous clear pulse for statistics and sync.
- in_sync  out  1  high while the state is CHECK.
- mismatch  out  1  one-cycle pulse, registered, on each bad beat.
- err_sticky  out  1  set on the first mismatch, cleared only by clr or reset.
- err_count  out  ERR_CNT_WIDTH  saturating mismatch count.
- beat_count  out  BEAT_CNT_WIDTH  accepted beats, wrapping.

Behaviour:
- Reset (arstn low, asynchronous): s_axis_tready=0, mismatch=0, err_sticky=0, err_count=0, beat_count=0, state=SYNC, expected=0, LFSR=LFSR_SEED.
- Accept condition: a beat is accepted when s_axis_tvalid & s_axis_tready are high at a rising edge.
- tready: registered, s_axis_tready <= en & rdy_src, where rdy_src is the feature-dependent source below. tready therefore follows en with 1-cycle latency.
- State SYNC:
  - In SYNC no comparison is made.
  - On an accepted beat: expected <= tdata+1, beat_count+1, go to CHECK.
- State CHECK, on an accepted beat:
  - beat_count+1.
  - If tdata==expected: expected <= expected+1.
  - Else: mismatch=1 for one cycle, err_sticky=1, err_count+1 (saturates at all-ones), expected <= tdata+1 (resync, so one dropped beat gives exactly 1 error).
- Wrap-around:
  - expected is width 8*BUS_WIDTH and wraps; all-ones followed by 0 is a match.
  - beat_count wraps silently.
- en low:
  - Next state is SYNC.
  - A beat accepted in that same cycle (tready still high) is counted in beat_count but not compared.
  - tready drops on the next edge.
- clr high:
  - Zeroes err_count, beat_count and err_sticky, clears mismatch, and sets state=SYNC.
  - Takes priority over a simultaneous accepted beat; that beat is consumed but neither counted nor checked.
  - LFSR and tready are unaffected.
- in_sync is combinational from the state register (high in CHECK). All other outputs are registered.
- Reset asserted mid-stream: everything returns to reset values immediately, and the next beat after release re-syncs.

Optional Feature:
- Macro: AXIS_SEQ_CHECKER_LFSR_READY_EN.
- Defined:
  - A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) advances every cycle, including while en is low.
  - rdy_src = LFSR bit 0, giving pseudo-random backpressure (~50%).
- Undefined:
  - No LFSR logic exists and LFSR_SEED is unused.
  - rdy_src = 1, so tready = en delayed one cycle.

Test Plan:
- Reset, en=1, source sends 0x00..0x1F continuously (BUS_WIDTH=1) -> beat_count=32, err_count=0, err_sticky=0, in_sync=1 after the first beat.
- Source sends 0x05,0x06,0x08,0x09 -> exactly one mismatch pulse on the 0x08 beat; err_count=1, err_sticky=1; 0x09 passes.
- Source counts 0xFD..0x02 across the wrap -> err_count=0, beat_count=6.
- Pulse clr on the same cycle as an accepted beat 0x40, then send 0x41,0x42 -> after clr: beat_count=0, err_count=0, err_sticky=0; next beat 0x41 re-syncs; final beat_count=2, err_count=0.
- Drop en mid-stream after beat 0x10, restart at 0x80 with en=1 -> tready low one cycle after en falls; no error on 0x80; in_sync low while en=0.
- With AXIS_SEQ_CHECKER_LFSR_READY_EN defined and tvalid held high for 1000 cycles -> tready matches a reference LFSR model seeded 16'hACE1 cycle-for-cycle, and 0 errors on an incrementing source that holds data until accepted.
